// File: rtl/select_funnel_rr_if.sv
// select_funnel_rr_if
//   Bundles the producer-side enqueue ports and the consumer-side dequeue
//   ports of select_funnel_rr.
//   Signals:
//     in__ENA    [NCH]          per-channel enqueue strobe
//     in_v       [NCH*WIDTH]    per-channel enqueue data, channel i at [i*WIDTH +: WIDTH]
//     in__RDY    [NCH]          per-channel not-full
//     out__ENA   [1]            dequeue strobe
//     out_v      [WIDTH]        head word of the granted channel
//     out_rindex [IDXW]         granted channel index, zero-extended
//     out__RDY   [1]            a word is presented
//     occ        [NCH*CW]       per-channel occupancy
//     err        [1]            sticky protocol error
//   Modports: master = producers/consumer side, slave = funnel side.
interface select_funnel_rr_if #(
  parameter int NCH   = 4,
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int IDXW  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NCH-1:0]       in__ENA;
  logic [NCH*WIDTH-1:0] in_v;
  logic [NCH-1:0]       in__RDY;
  logic                 out__ENA;
  logic [WIDTH-1:0]     out_v;
  logic [IDXW-1:0]      out_rindex;
  logic                 out__RDY;
  logic [NCH*CW-1:0]    occ;
  logic                 err;

  modport master (
    output in__ENA, in_v, out__ENA,
    input  in__RDY, out_v, out_rindex, out__RDY, occ, err
  );

  modport slave (
    input  in__ENA, in_v, out__ENA,
    output in__RDY, out_v, out_rindex, out__RDY, occ, err
  );
endinterface

// File: rtl/select_funnel_rr.sv
// select_funnel_rr
//   N-channel buffered funnel. Each channel owns a DEPTH-entry FIFO; one
//   output port drains them, tagging each word with its source channel.
//   MODE 0 = work-conserving round-robin, MODE 1 = fixed priority (lowest
//   index wins). A presented-but-unconsumed word is locked until taken.
//   Ports:
//     CLK   clock, rising edge
//     nRST  asynchronous active-low reset
//     bus   select_funnel_rr_if.slave (enqueue/dequeue handshakes, occ, err)
module select_funnel_rr #(
  parameter int NCH   = 4,
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int IDXW  = 8,
  parameter int MODE  = 0
) (
  input logic               CLK,
  input logic               nRST,
  select_funnel_rr_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CHW = $clog2(NCH);

  typedef enum logic {ARB, HOLD} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem    [NCH][DEPTH];
  logic [PW-1:0]    rd_ptr [NCH];
  logic [PW-1:0]    wr_ptr [NCH];
  logic [CW-1:0]    cnt    [NCH];

  logic [NCH-1:0]   nonempty;
  logic [NCH-1:0]   full;
  logic [NCH-1:0]   enq;
  logic [NCH-1:0]   deq_vec;
  logic             any_ne;

  logic [CHW-1:0]   rr;
  logic [CHW-1:0]   g;
  logic [CHW-1:0]   cand;
  logic [CHW-1:0]   sel;
  logic             present;
  logic             deq;
  logic             lock_en;
  logic             err_q;

  logic [WIDTH-1:0] head_v;
  logic [WIDTH-1:0] last_v;
  logic [CHW-1:0]   last_idx;

  // ---------------- per-channel status ----------------
  always_comb begin
    nonempty = '0;
    full     = '0;
    enq      = '0;
    deq_vec  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      nonempty[i] = (cnt[i] != '0);
      full[i]     = (cnt[i] == CW'(DEPTH));
      enq[i]      = bus.in__ENA[i] & ~full[i];
      deq_vec[i]  = deq & (sel == CHW'(i));
    end
  end

  assign any_ne = |nonempty;

  // ---------------- FIFOs ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (enq[i])     wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (deq_vec[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(enq[i]) - CW'(deq_vec[i]);
      end
    end
  end

  // Storage carries no reset; an empty FIFO never exposes its contents.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (enq[i]) mem[i][wr_ptr[i]] <= bus.in_v[i*WIDTH +: WIDTH];
    end
  end

  // ---------------- candidate search ----------------
  // Cyclic scan from a base channel: rr in round-robin mode, 0 in priority
  // mode, so both policies share one first-nonempty search.
  always_comb begin
    logic          found;
    int unsigned   base;
    int unsigned   idx;
    cand  = '0;
    found = 1'b0;
    base  = (MODE == 0) ? 32'(rr) : 0;
    idx   = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = (base + k) % NCH;
      if (!found && nonempty[idx[CHW-1:0]]) begin
        cand  = idx[CHW-1:0];
        found = 1'b1;
      end
    end
  end

  // ---------------- arbiter FSM ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ARB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:  if (any_ne && !bus.out__ENA) state_nxt = HOLD;
      HOLD: if (bus.out__ENA)            state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    sel     = (state == HOLD) ? g : cand;
    present = (state == HOLD) || any_ne;
    lock_en = (state == ARB) && any_ne && !bus.out__ENA;
    deq     = present && bus.out__ENA;
  end

  assign head_v = mem[sel][rd_ptr[sel]];

  // ---------------- grant / pointer / error registers ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      g        <= '0;
      rr       <= '0;
      last_v   <= '0;
      last_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      if (lock_en) g <= cand;
      if (deq)     rr <= (sel == CHW'(NCH-1)) ? '0 : sel + CHW'(1);
      // Remember the presented word so the outputs hold once all drain.
      if (present) begin
        last_v   <= head_v;
        last_idx <= sel;
      end
      if ((bus.out__ENA && !present) || |(bus.in__ENA & full)) err_q <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign bus.in__RDY    = ~full;
  assign bus.out__RDY   = present;
  assign bus.out_v      = present ? head_v : last_v;
  assign bus.out_rindex = IDXW'(present ? sel : last_idx);
  assign bus.err        = err_q;

  always_comb begin
    bus.occ = '0;
    for (int unsigned i = 0; i < NCH; i++) bus.occ[i*CW +: CW] = cnt[i];
  end
endmodule
